// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller: FSM state
// encoding, the architectural zero register and the stall/flush bundle.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_SQUASH   = 2'd2
  } ctrl_state_e;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_stall;
  } stall_bundle_t;

  localparam stall_bundle_t BUNDLE_IDLE = stall_bundle_t'(5'b00000);

  // True when the load in EX writes a register the ID instruction reads.
  function automatic logic load_use_hit(
    input logic       ex_valid,
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic [4:0] id_rs1,
    input logic [4:0] id_rs2,
    input logic       id_use_rs1,
    input logic       id_use_rs2
  );
    logic rs1_hit;
    logic rs2_hit;
    rs1_hit = id_use_rs1 & (id_rs1 == ex_rd);
    rs2_hit = id_use_rs2 & (id_rs2 == ex_rd);
    return ex_valid & ex_mem_read & (ex_rd != REG_X0) & (rs1_hit | rs2_hit);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: hazard sources from the
// ID/EX/MEM stages in, per-stage stall/flush controls and redirect out.
interface pipeline_hazard_ctrl_if #(
  parameter int XLEN = 32
);
  logic            mem_busy;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic            ex_valid;
  logic            ex_mem_read;
  logic [4:0]      ex_rd;
  logic            ex_mispredict;
  logic            ex_jump;
  logic [XLEN-1:0] ex_target_pc;

  logic            pc_stall;
  logic            if_id_stall;
  logic            if_id_flush;
  logic            id_ex_flush;
  logic            ex_mem_stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  // Pipeline side: reports hazard sources, consumes the controls.
  modport master (
    output mem_busy, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_valid, ex_mem_read, ex_rd, ex_mispredict, ex_jump, ex_target_pc,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall,
           redirect_valid, redirect_pc
  );

  // Controller side.
  modport slave (
    input  mem_busy, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_valid, ex_mem_read, ex_rd, ex_mispredict, ex_jump, ex_target_pc,
    output pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts inc pulses, freezes while hold is high,
// and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             hold,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_r;

  // Count register with synchronous clear and saturation at the top value.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_r <= '0;
    end else if (hold) begin
      value_r <= value_r;
    end else if (inc && (value_r != {CNT_W{1'b1}})) begin
      value_r <= value_r + CNT_W'(1);
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/redirect sequencer for the 5-stage core. Arbitrates
// memory-busy freeze, EX redirects and ID load-use hazards, and keeps
// saturating performance counters for each event class.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int CNT_W         = 32,
  parameter int SQUASH_CYCLES = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz,
  output logic [1:0]             ctrl_state,
  output logic [CNT_W-1:0]       stat_mispredicts,
  output logic [CNT_W-1:0]       stat_jumps,
  output logic [CNT_W-1:0]       stat_stalls
);

  localparam int SQ_W = (SQUASH_CYCLES < 2) ? 1 : $clog2(SQUASH_CYCLES + 1);

  ctrl_state_e     state_r;
  ctrl_state_e     state_nxt_s;
  logic [SQ_W-1:0] sq_cnt_r;
  logic [SQ_W-1:0] sq_nxt_s;
  stall_bundle_t   ctrl_s;
  logic            redirect_valid_s;
  logic [XLEN-1:0] redirect_pc_s;
  logic            redirect_ev_s;
  logic            load_use_s;
  logic            inc_mis_s;
  logic            inc_jmp_s;
  logic            inc_stl_s;

  assign redirect_ev_s = hz.ex_valid & (hz.ex_mispredict | hz.ex_jump);
  assign load_use_s    = load_use_hit(hz.ex_valid, hz.ex_mem_read, hz.ex_rd,
                                      hz.id_rs1, hz.id_rs2,
                                      hz.id_use_rs1, hz.id_use_rs2);

  // Hazard arbitration: reset > mem_busy > redirect > load-use, with the
  // squash shadow and the post-stall cycle ignoring EX/ID events entirely.
  always_comb begin
    ctrl_s           = BUNDLE_IDLE;
    redirect_valid_s = 1'b0;
    redirect_pc_s    = '0;
    inc_mis_s        = 1'b0;
    inc_jmp_s        = 1'b0;
    inc_stl_s        = 1'b0;
    state_nxt_s      = state_r;
    sq_nxt_s         = sq_cnt_r;
    if (reset) begin
      state_nxt_s = ST_RUN;
      sq_nxt_s    = '0;
    end else if (hz.mem_busy) begin
      ctrl_s.pc_stall     = 1'b1;
      ctrl_s.if_id_stall  = 1'b1;
      ctrl_s.ex_mem_stall = 1'b1;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (redirect_ev_s) begin
            redirect_valid_s   = 1'b1;
            redirect_pc_s      = hz.ex_target_pc;
            ctrl_s.if_id_flush = 1'b1;
            ctrl_s.id_ex_flush = 1'b1;
            inc_mis_s          = hz.ex_mispredict;
            inc_jmp_s          = ~hz.ex_mispredict;
            state_nxt_s        = ST_SQUASH;
            sq_nxt_s           = SQ_W'(SQUASH_CYCLES);
          end else if (load_use_s) begin
            ctrl_s.pc_stall    = 1'b1;
            ctrl_s.if_id_stall = 1'b1;
            ctrl_s.id_ex_flush = 1'b1;
            inc_stl_s          = 1'b1;
            state_nxt_s        = ST_LU_STALL;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_LU_STALL: begin
          state_nxt_s = ST_RUN;
        end
        ST_SQUASH: begin
          if (sq_cnt_r <= SQ_W'(1)) begin
            state_nxt_s = ST_RUN;
            sq_nxt_s    = '0;
          end else begin
            sq_nxt_s = sq_cnt_r - SQ_W'(1);
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
          sq_nxt_s    = '0;
        end
      endcase
    end
  end

  // FSM state and squash-shadow countdown.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_RUN;
      sq_cnt_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      sq_cnt_r <= sq_nxt_s;
    end
  end

  assign hz.pc_stall       = ctrl_s.pc_stall;
  assign hz.if_id_stall    = ctrl_s.if_id_stall;
  assign hz.if_id_flush    = ctrl_s.if_id_flush;
  assign hz.id_ex_flush    = ctrl_s.id_ex_flush;
  assign hz.ex_mem_stall   = ctrl_s.ex_mem_stall;
  assign hz.redirect_valid = redirect_valid_s;
  assign hz.redirect_pc    = redirect_pc_s;
  assign ctrl_state        = state_r;

  sat_counter #(.CNT_W(CNT_W)) u_cnt_mis (
    .clock (clock),
    .reset (reset),
    .inc   (inc_mis_s),
    .hold  (hz.mem_busy),
    .value (stat_mispredicts)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_jmp (
    .clock (clock),
    .reset (reset),
    .inc   (inc_jmp_s),
    .hold  (hz.mem_busy),
    .value (stat_jumps)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_stl (
    .clock (clock),
    .reset (reset),
    .inc   (inc_stl_s),
    .hold  (hz.mem_busy),
    .value (stat_stalls)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (narrow counters and a two-cycle
// squash shadow so saturation and the countdown are both exercised).
module tb_pipeline_hazard_ctrl;

  localparam int XLEN = 32;
  localparam int CNT_W = 4;
  localparam int SQ = 2;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clock;
  logic reset;
  logic [1:0] ctrl_state;
  logic [CNT_W-1:0] stat_mispredicts;
  logic [CNT_W-1:0] stat_jumps;
  logic [CNT_W-1:0] stat_stalls;

  pipeline_hazard_ctrl_if #(.XLEN(XLEN)) hz ();

  pipeline_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .SQUASH_CYCLES(SQ)) dut (
    .clock            (clock),
    .reset            (reset),
    .hz               (hz),
    .ctrl_state       (ctrl_state),
    .stat_mispredicts (stat_mispredicts),
    .stat_jumps       (stat_jumps),
    .stat_stalls      (stat_stalls)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_mis = 0;

  // reference model state: mode 0=running, 1=after load-use, 2=wrong-path shadow
  int m_mode = 0;
  int m_left = 0;
  int m_cm = 0;
  int m_cj = 0;
  int m_cs = 0;
  bit m_valid = 1'b0;

  // hand-computed expectations for the current cycle (-1 = not pinned)
  int pin_pcst = -1;
  int pin_idexf = -1;
  int pin_rv = -1;
  int pin_rpc = -1;
  int pin_state = -1;
  int pin_mis = -1;
  int pin_jumps = -1;
  int pin_stalls = -1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  int e_pcst, e_ifst, e_iff, e_idf, e_exst, e_rv;
  longint e_rpc;
  int x_mode, x_left, x_cm, x_cj, x_cs;
  bit lu, ev;

  // Model + compare on every falling edge; commit model state for the next cycle.
  always @(negedge clock) begin
    lu = hz.ex_valid && hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
         ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
          (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
    ev = hz.ex_valid && (hz.ex_mispredict || hz.ex_jump);
    e_pcst = 0; e_ifst = 0; e_iff = 0; e_idf = 0; e_exst = 0; e_rv = 0; e_rpc = 0;
    x_mode = m_mode; x_left = m_left; x_cm = m_cm; x_cj = m_cj; x_cs = m_cs;
    if (reset) begin
      x_mode = 0; x_left = 0; x_cm = 0; x_cj = 0; x_cs = 0;
    end else if (hz.mem_busy) begin
      e_pcst = 1; e_ifst = 1; e_exst = 1;
    end else if (m_mode == 0 && ev) begin
      e_rv = 1; e_rpc = longint'(hz.ex_target_pc); e_iff = 1; e_idf = 1;
      x_mode = 2; x_left = SQ;
      if (hz.ex_mispredict) x_cm = (m_cm < CMAX) ? m_cm + 1 : CMAX;
      else x_cj = (m_cj < CMAX) ? m_cj + 1 : CMAX;
    end else if (m_mode == 0 && lu) begin
      e_pcst = 1; e_ifst = 1; e_idf = 1;
      x_mode = 1;
      x_cs = (m_cs < CMAX) ? m_cs + 1 : CMAX;
    end else if (m_mode == 1) begin
      x_mode = 0;
    end else if (m_mode == 2) begin
      x_left = m_left - 1;
      if (x_left == 0) x_mode = 0;
    end

    chk("pc_stall", hz.pc_stall, e_pcst);
    chk("if_id_stall", hz.if_id_stall, e_ifst);
    chk("if_id_flush", hz.if_id_flush, e_iff);
    chk("id_ex_flush", hz.id_ex_flush, e_idf);
    chk("ex_mem_stall", hz.ex_mem_stall, e_exst);
    chk("redirect_valid", hz.redirect_valid, e_rv);
    chk("redirect_pc", longint'(hz.redirect_pc), e_rpc);
    if (m_valid) begin
      chk("ctrl_state", ctrl_state, m_mode);
      chk("stat_mispredicts", stat_mispredicts, m_cm);
      chk("stat_jumps", stat_jumps, m_cj);
      chk("stat_stalls", stat_stalls, m_cs);
    end

    if (pin_pcst >= 0) chk("lit_pc_stall", hz.pc_stall, pin_pcst);
    if (pin_idexf >= 0) chk("lit_id_ex_flush", hz.id_ex_flush, pin_idexf);
    if (pin_rv >= 0) chk("lit_redirect_valid", hz.redirect_valid, pin_rv);
    if (pin_rpc >= 0) chk("lit_redirect_pc", longint'(hz.redirect_pc), pin_rpc);
    if (pin_state >= 0) chk("lit_ctrl_state", ctrl_state, pin_state);
    if (pin_mis >= 0) chk("lit_stat_mispredicts", stat_mispredicts, pin_mis);
    if (pin_jumps >= 0) chk("lit_stat_jumps", stat_jumps, pin_jumps);
    if (pin_stalls >= 0) chk("lit_stat_stalls", stat_stalls, pin_stalls);

    m_mode = x_mode; m_left = x_left; m_cm = x_cm; m_cj = x_cj; m_cs = x_cs;
    if (reset) m_valid = 1'b1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
    pin_pcst = -1; pin_idexf = -1; pin_rv = -1; pin_rpc = -1;
    pin_state = -1; pin_mis = -1; pin_jumps = -1; pin_stalls = -1;
  endtask

  task automatic set_ex(input logic v, input logic mr, input logic [4:0] rd,
                        input logic mp, input logic jp, input logic [31:0] tgt);
    hz.ex_valid = v; hz.ex_mem_read = mr; hz.ex_rd = rd;
    hz.ex_mispredict = mp; hz.ex_jump = jp; hz.ex_target_pc = tgt;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2);
    hz.id_rs1 = rs1; hz.id_rs2 = rs2; hz.id_use_rs1 = u1; hz.id_use_rs2 = u2;
  endtask

  task automatic idle();
    hz.mem_busy = 1'b0;
    set_ex(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    set_id(5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    pin_state = 0; pin_stalls = 0; pin_jumps = 0; pin_pcst = 0;
    tick();
    reset = 1'b0;
    tick();
    pin_state = 0; pin_pcst = 0;
    tick();

    // lw x5 in EX, ID reads rs2=x5
    set_ex(1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0); set_id(5'd1, 5'd5, 1'b0, 1'b1);
    pin_pcst = 1; pin_idexf = 1; pin_stalls = 0;
    tick();
    pin_state = 1; pin_pcst = 0; pin_idexf = 0; pin_stalls = 1;
    tick();
    idle(); pin_state = 0; pin_stalls = 1;
    tick();

    // load to x0 and unused source: no stall; then real rs1 hit
    set_ex(1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0); set_id(5'd0, 5'd0, 1'b1, 1'b0);
    pin_pcst = 0;
    tick();
    set_ex(1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 32'h0); set_id(5'd7, 5'd3, 1'b0, 1'b1);
    pin_pcst = 0;
    tick();
    set_id(5'd7, 5'd3, 1'b1, 1'b0); pin_pcst = 1;
    tick();
    idle(); pin_state = 1; pin_stalls = 2;
    tick();

    // mispredict to 0x40 with a simultaneous load-use
    set_ex(1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 32'h40); set_id(5'd5, 5'd0, 1'b1, 1'b0);
    pin_rv = 1; pin_rpc = 32'h40; pin_pcst = 0; pin_idexf = 1;
    tick();
    set_ex(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 32'h80);
    pin_rv = 0; pin_rpc = 0; pin_state = 2; pin_mis = 1; pin_stalls = 2;
    tick();
    pin_rv = 0; pin_state = 2;
    tick();
    idle(); pin_state = 0;
    tick();

    // redirect request on a bubble is ignored
    set_ex(1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 32'h44); pin_rv = 0; pin_rpc = 0;
    tick();
    set_ex(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'h100); pin_rv = 1; pin_rpc = 32'h100;
    tick();
    idle(); pin_jumps = 1; pin_mis = 1;
    tick();
    tick();
    // mispredict and jump together counts as mispredict only
    set_ex(1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 32'h104); pin_rv = 1;
    tick();
    idle(); pin_mis = 2; pin_jumps = 1;
    tick();
    tick();

    // mem_busy holds a pending mispredict for three cycles
    set_ex(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 32'h200);
    hz.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pin_rv = 0; pin_pcst = 1; pin_state = 0;
      tick();
    end
    hz.mem_busy = 1'b0; pin_rv = 1; pin_rpc = 32'h200; pin_mis = 2;
    tick();
    // mem_busy during the shadow freezes the countdown
    idle(); hz.mem_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pin_state = 2; pin_mis = 3; pin_pcst = 1;
      tick();
    end
    hz.mem_busy = 1'b0; pin_state = 2;
    tick();
    pin_state = 2;
    tick();
    pin_state = 0;
    tick();

    // reset in the middle of the shadow
    set_ex(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'h300);
    tick();
    set_ex(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 32'h304); reset = 1'b1;
    pin_rv = 0; pin_pcst = 0; pin_state = 2; pin_jumps = 2;
    tick();
    reset = 1'b0; idle(); pin_state = 0; pin_jumps = 0; pin_mis = 0; pin_stalls = 0;
    tick();

    // 17 jumps into a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      set_ex(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'h1000 + 32'(i * 4));
      pin_rv = 1;
      if (i == 16) pin_jumps = 15;
      tick();
      idle();
      tick();
      tick();
    end
    pin_jumps = 15;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
